regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-port register file for the pipelined core: NUM_RD combinational read ports,
//  two write ports (ALU/mem writeback), same-cycle write-to-read bypass, a per-register pending-write
//  scoreboard for hazard detection, and a PC alias index that always reads PC_IN.
//  Sits between decode (reads, issue) and writeback (writes).
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  4   register index width; depth = 2**ADDR_W
//  NUM_RD  3   number of read ports
//  PC_IDX  15  index aliased to PC_IN; no storage, never written, never busy
// PORTS
//  CLK      in   1              clock, all state updates on rising edge
//  RESET    in   1              synchronous, active-high reset
//  RA       in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//  RD       out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W], combinational
//  RBUSY    out  NUM_RD         1 = port k's register has an outstanding producer
//  PC_IN    in   DATA_W         value returned for reads of PC_IDX
//  WE0      in   1              write port 0 enable
//  WA0      in   ADDR_W         write port 0 address
//  WD0      in   DATA_W         write port 0 data
//  WE1      in   1              write port 1 enable (wins on address collision)
//  WA1      in   ADDR_W         write port 1 address
//  WD1      in   DATA_W         write port 1 data
//  ISSUE_EN in   1              mark ISSUE_A as pending (instruction issued with that destination)
//  ISSUE_A  in   ADDR_W         destination index being issued
//  BUSY     out  2**ADDR_W      full scoreboard vector, bit i = register i pending
// BEHAVIOUR
//  - Reset: at a posedge with RESET=1, all stored registers clear to 0 and all BUSY bits clear.
//    RESET overrides any write or issue in that cycle. Next cycle every non-PC read returns 0
//    and RBUSY = 0 (ignoring bypass from writes in that cycle).
//  - Write: at posedge, if WEn=1 and WAn!=PC_IDX, reg[WAn] <= WDn. If WE0 and WE1 target the same
//    address, WD1 is stored. Writes to PC_IDX are discarded.
//  - Read (combinational, zero latency), per port k, address a = RA[k]:
//    a==PC_IDX          -> PC_IN
//    WE1 && WA1==a      -> WD1 (bypass)
//    WE0 && WA0==a      -> WD0 (bypass)
//    otherwise          -> reg[a]
//  - Scoreboard, per index i != PC_IDX, next-state priority:
//    RESET -> 0; ISSUE_EN && ISSUE_A==i -> 1; (WE0&&WA0==i)||(WE1&&WA1==i) -> 0; else hold.
//    Issue and writeback to the same index in the same cycle leave the bit SET
//    (new producer supersedes the old).
//    BUSY[PC_IDX] is constant 0; ISSUE to PC_IDX is ignored.
//    Issue to an already-busy index keeps it busy (no count; single outstanding producer assumed).
//  - RBUSY[k] = BUSY[RA[k]] && !(any enabled write to RA[k] this cycle), i.e. a writeback
//    resolves the hazard combinationally in the same cycle the bypassed data is presented.
//    RBUSY[k] = 0 for PC_IDX.
//  - No internal latency beyond one posedge for write/scoreboard update; all outputs are
//    functions of current state and inputs.
// TESTING
//  1. RESET=1 one cycle after random writes -> all RA reads return 0, BUSY=0.
//  2. WE0=1 WA0=3 WD0=0xDEADBEEF, RA[0]=3 same cycle -> RD[0]=0xDEADBEEF (bypass);
//     next cycle WE0=0 -> RD[0]=0xDEADBEEF (stored).
//  3. WE0/WE1 both to addr 5, WD0=0x11, WD1=0x22 -> same-cycle RD=0x22,
//     next cycle reg[5]=0x22.
//  4. ISSUE_EN, ISSUE_A=7 -> next cycle BUSY[7]=1, RBUSY=1 for RA=7;
//     WE1 WA1=7 -> RBUSY=0 that cycle, BUSY[7]=0 next cycle.
//  5. ISSUE_A=7 and WE0 WA0=7 same cycle with BUSY[7]=1 -> BUSY[7] stays 1, reg[7]=WD0.
//  6. PC_IN=0x100, write/issue to 15 -> reads of 15 return 0x100, BUSY[15]=0;
//     RESET asserted with WE0 active -> write dropped, reg=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass, pending-write scoreboard and PC alias
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] RD,
    output logic [NUM_RD-1:0]        RBUSY,
    input  logic [DATA_W-1:0]        PC_IN,
    input  logic                     WE0,
    input  logic [ADDR_W-1:0]        WA0,
    input  logic [DATA_W-1:0]        WD0,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WA1,
    input  logic [DATA_W-1:0]        WD1,
    input  logic                     ISSUE_EN,
    input  logic [ADDR_W-1:0]        ISSUE_A,
    output logic [2**ADDR_W-1:0]     BUSY
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    // Next state: port 1 overrides port 0; a new issue supersedes a same-cycle writeback; PC slot stays empty
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (ADDR_W'(i) == PC_A) ? '0 :
                        (WE1 && WA1 == ADDR_W'(i)) ? WD1 :
                        (WE0 && WA0 == ADDR_W'(i)) ? WD0 : regs_q[i];
            busy_d[i] = (ADDR_W'(i) == PC_A) ? 1'b0 :
                        (ISSUE_EN && ISSUE_A == ADDR_W'(i)) ? 1'b1 :
                        ((WE0 && WA0 == ADDR_W'(i)) || (WE1 && WA1 == ADDR_W'(i))) ? 1'b0 : busy_q[i];
        end
    end

    // State registers; reset drops any write or issue of the same cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            busy_q <= busy_d;
        end
    end

    assign BUSY = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = RA[k*ADDR_W +: ADDR_W];
        assign hit = (WE0 && WA0 == a) || (WE1 && WA1 == a);
        assign RD[k*DATA_W +: DATA_W] = (a == PC_A) ? PC_IN :
                                        (WE1 && WA1 == a) ? WD1 :
                                        (WE0 && WA0 == a) ? WD0 : regs_q[a];
        assign RBUSY[k] = (a != PC_A) && busy_q[a] && !hit;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks against a sequential reference model
module tb_regfile_scoreboard;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [11:0] RA;
    logic [95:0] RD;
    logic [2:0]  RBUSY;
    logic [31:0] PC_IN, WD0, WD1;
    logic        WE0, WE1, ISSUE_EN;
    logic [3:0]  WA0, WA1, ISSUE_A;
    logic [15:0] BUSY;

    logic [31:0] mm [16];
    logic        mb [16];
    int          ncmp = 0;
    int          nerr = 0;

    regfile_scoreboard dut (
        .CLK(CLK), .RESET(RESET), .RA(RA), .RD(RD), .RBUSY(RBUSY), .PC_IN(PC_IN),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .ISSUE_EN(ISSUE_EN), .ISSUE_A(ISSUE_A), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RESET = 0; WE0 = 0; WE1 = 0; ISSUE_EN = 0;
        WA0 = 0; WA1 = 0; ISSUE_A = 0; WD0 = 0; WD1 = 0;
    endtask

    // Reference: writes apply in port order (port 1 last), then writebacks clear, then issue sets
    task automatic tick();
        @(posedge CLK);
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin mm[i] = 0; mb[i] = 0; end
        end else begin
            if (WE0 && WA0 != 15) mm[WA0] = WD0;
            if (WE1 && WA1 != 15) mm[WA1] = WD1;
            if (WE0) mb[WA0] = 0;
            if (WE1) mb[WA1] = 0;
            if (ISSUE_EN && ISSUE_A != 15) mb[ISSUE_A] = 1;
        end
        #2;
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  a;
        logic [31:0] e;
        logic        eb;
        logic [15:0] ev;
        #1;
        for (int k = 0; k < 3; k++) begin
            a = RA[k*4 +: 4];
            if (a == 15) e = PC_IN;
            else if (WE1 && WA1 == a) e = WD1;
            else if (WE0 && WA0 == a) e = WD0;
            else e = mm[a];
            eb = (a != 15) && mb[a] && !(WE0 && WA0 == a) && !(WE1 && WA1 == a);
            chk($sformatf("%s rd%0d", tag, k), RD[k*32 +: 32], e);
            chk($sformatf("%s rbusy%0d", tag, k), {31'b0, RBUSY[k]}, {31'b0, eb});
        end
        for (int i = 0; i < 16; i++) ev[i] = mb[i];
        chk($sformatf("%s busy", tag), {16'b0, BUSY}, {16'b0, ev});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mm[i] = 0; mb[i] = 0; end
        idle(); PC_IN = 32'h100; RA = 0;
        RESET = 1; tick(); tick(); idle();

        // random writes and issues, then reset with a live write to 9
        for (int n = 0; n < 6; n++) begin
            WE0 = 1; WA0 = 4'($urandom_range(0, 14)); WD0 = $urandom;
            ISSUE_EN = 1; ISSUE_A = 4'($urandom_range(0, 14)); tick();
        end
        idle(); WE0 = 1; WA0 = 9; WD0 = 32'hAA; tick();
        idle(); RESET = 1; WE0 = 1; WA0 = 9; WD0 = 32'h55; ISSUE_EN = 1; ISSUE_A = 2; tick();
        idle(); RA = {4'd7, 4'd9, 4'd3};
        check_model("reset");
        chk("reset rd9", RD[63:32], 32'h0);
        chk("reset busy", {16'b0, BUSY}, 32'h0);

        // bypass then stored
        WE0 = 1; WA0 = 3; WD0 = 32'hDEADBEEF; RA = {4'd0, 4'd0, 4'd3};
        check_model("byp");
        chk("byp rd0", RD[31:0], 32'hDEADBEEF);
        tick(); idle();
        check_model("stored");
        chk("stored rd0", RD[31:0], 32'hDEADBEEF);

        // write collision: port 1 wins
        WE0 = 1; WA0 = 5; WD0 = 32'h11; WE1 = 1; WA1 = 5; WD1 = 32'h22; RA = {4'd0, 4'd5, 4'd3};
        check_model("coll");
        chk("coll byp", RD[63:32], 32'h22);
        tick(); idle();
        chk("coll stored", RD[63:32], 32'h22);

        // issue then resolve by writeback
        ISSUE_EN = 1; ISSUE_A = 7; tick(); idle(); RA = {4'd7, 4'd5, 4'd3};
        check_model("issue");
        chk("issue busy7", {31'b0, BUSY[7]}, 32'h1);
        chk("issue rbusy2", {31'b0, RBUSY[2]}, 32'h1);
        WE1 = 1; WA1 = 7; WD1 = 32'h1234;
        check_model("wb");
        chk("wb rbusy2", {31'b0, RBUSY[2]}, 32'h0);
        tick(); idle();
        chk("wb busy7", {31'b0, BUSY[7]}, 32'h0);

        // issue and writeback together on a busy register
        ISSUE_EN = 1; ISSUE_A = 7; tick();
        idle(); ISSUE_EN = 1; ISSUE_A = 7; WE0 = 1; WA0 = 7; WD0 = 32'h77; tick(); idle();
        check_model("iss+wb");
        chk("iss+wb busy7", {31'b0, BUSY[7]}, 32'h1);
        chk("iss+wb rd7", RD[95:64], 32'h77);

        // PC alias
        PC_IN = 32'h100; WE0 = 1; WA0 = 15; WD0 = 32'hBAD; WE1 = 1; WA1 = 15; WD1 = 32'hBAD1;
        ISSUE_EN = 1; ISSUE_A = 15; RA = {4'd15, 4'd15, 4'd15};
        check_model("pc");
        chk("pc byp", RD[31:0], 32'h100);
        tick(); idle();
        check_model("pc after");
        chk("pc rd", RD[95:64], 32'h100);
        chk("pc busy15", {31'b0, BUSY[15]}, 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            RESET = ($urandom_range(0, 49) == 0);
            WE0 = 1'($urandom); WA0 = 4'($urandom); WD0 = $urandom;
            WE1 = 1'($urandom); WA1 = ($urandom_range(0, 3) == 0) ? WA0 : 4'($urandom); WD1 = $urandom;
            ISSUE_EN = 1'($urandom); ISSUE_A = 4'($urandom);
            RA = 12'($urandom); PC_IN = $urandom;
            check_model("rand");
            tick();
        end
        idle(); check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
